// File: rtl/par_reg_arbiter_pkg.sv
// par_reg_arbiter_pkg: state encoding and elaboration helpers shared by the
// parallel-register arbiter and its round-robin picker.
package par_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_ACK  = 2'd3
    } state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/par_reg_arbiter_rr_pick.sv
// par_reg_arbiter_rr_pick: combinational round-robin picker; the search starts
// one past the pointer and wraps, the first active requester wins.
module par_reg_arbiter_rr_pick
    import par_reg_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = clog2(NREQ)
)(
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   idx_o,
    output logic            vld_o
);

    // Scan from farthest to nearest so the nearest active slot overwrites.
    always_comb begin
        idx_o = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) idx_o = IW'((int'(ptr_i) + k) % NREQ);
        end
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/par_reg_arbiter.sv
// par_reg_arbiter: round-robin sequencer sharing one parallel storage register
// (EWR write strobe, active-low EDY read enable) among NREQ requesters.
module par_reg_arbiter
    import par_reg_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int RD_WAIT  = 1,
    parameter int INV_READ = 1,
    localparam int IW = clog2(NREQ)
)(
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic [NREQ-1:0]         REQ_WR,
    input  logic [NREQ-1:0]         REQ_RD,
    input  logic [NREQ*WIDTH-1:0]   WDATA,
    output logic [NREQ-1:0]         ACK,
    output logic [WIDTH-1:0]        RDATA,
    output logic [IW-1:0]           GNT_ID,
    output logic                    BUSY,
    output logic [WIDTH-1:0]        REG_DATA,
    output logic                    REG_EWR,
    output logic                    REG_EDY,
    input  logic [WIDTH-1:0]        REG_Q
);

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, gnt_q, gnt_d, win;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             busy_q, ewr_q, edy_q, vld, last;

    par_reg_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i(REQ_WR | REQ_RD),
        .ptr_i(ptr_q),
        .idx_o(win),
        .vld_o(vld)
    );

    assign last = cnt_q == 4'(RD_WAIT - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (vld) begin
                state_d = REQ_WR[win] ? S_WR : S_RD;
                ptr_d   = win;
                gnt_d   = win;
            end
            S_WR: state_d = S_ACK;
            S_RD: begin
                cnt_d = cnt_q + 4'd1;
                if (last) begin
                    state_d = S_ACK;
                    rdata_d = (INV_READ != 0) ? ~REG_Q : REG_Q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ack_d        = '0;
        ack_d[gnt_d] = state_d == S_ACK;
    end

    // Strobes and flags are registered from the next state so they line up with it.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(NREQ - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            ewr_q   <= 1'b0;
            edy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= state_d != S_IDLE;
            ewr_q   <= state_d == S_WR;
            edy_q   <= state_d != S_RD;
        end
    end

    assign ACK      = ack_q;
    assign RDATA    = rdata_q;
    assign GNT_ID   = gnt_q;
    assign BUSY     = busy_q;
    assign REG_EWR  = ewr_q;
    assign REG_EDY  = edy_q;
    assign REG_DATA = (state_q == S_WR) ? WDATA[gnt_q*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_par_reg_arbiter.sv
// tb_par_reg_arbiter: directed stimulus against a transaction-schedule model of
// the arbiter, checked every cycle, plus hand-computed literal expectations.
module tb_par_reg_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int RD_WAIT = 3;

    logic                  CLOCK = 1'b0;
    logic                  RESET = 1'b1;
    logic [NREQ-1:0]       REQ_WR = '0;
    logic [NREQ-1:0]       REQ_RD = '0;
    logic [NREQ*WIDTH-1:0] WDATA = '0;
    logic [NREQ-1:0]       ACK;
    logic [WIDTH-1:0]      RDATA, REG_DATA, REG_Q;
    logic [WIDTH-1:0]      mem = '0;
    logic [1:0]            GNT_ID;
    logic                  BUSY, REG_EWR, REG_EDY;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit rr     = 1'b0;
    logic [NREQ-1:0] pend = '0;

    always #5 CLOCK = ~CLOCK;

    par_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .RD_WAIT(RD_WAIT), .INV_READ(1)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQ_WR(REQ_WR), .REQ_RD(REQ_RD), .WDATA(WDATA),
        .ACK(ACK), .RDATA(RDATA), .GNT_ID(GNT_ID), .BUSY(BUSY), .REG_DATA(REG_DATA),
        .REG_EWR(REG_EWR), .REG_EDY(REG_EDY), .REG_Q(REG_Q)
    );

    // Storage register that drives its contents inverted.
    always @(posedge CLOCK) if (REG_EWR) mem <= REG_DATA;
    assign REG_Q = ~mem;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Model: a grant expands into a list of per-cycle output steps.
    typedef struct {
        logic             ewr;
        logic             edy;
        logic [NREQ-1:0]  ack;
        logic [WIDTH-1:0] data;
        logic             rd_done;
        logic [WIDTH-1:0] rv;
    } step_t;

    function automatic step_t mk(logic ewr, logic edy, logic [NREQ-1:0] ack,
                                 logic [WIDTH-1:0] data, logic rd_done, logic [WIDTH-1:0] rv);
        step_t s;
        s.ewr = ewr; s.edy = edy; s.ack = ack; s.data = data; s.rd_done = rd_done; s.rv = rv;
        return s;
    endfunction

    step_t            sched[$];
    step_t            cur;
    logic             m_ewr, m_edy, m_busy;
    logic [NREQ-1:0]  m_ack;
    logic [WIDTH-1:0] m_data, m_rdata, m_mem = '0;
    int               m_gnt, m_ptr, w, j;

    always @(posedge CLOCK) begin
        if (RESET) begin
            sched.delete();
            m_busy = 0; m_ewr = 0; m_edy = 1; m_ack = '0; m_data = '0;
            m_rdata = '0; m_gnt = 0; m_ptr = NREQ - 1;
        end else begin
            if (sched.size() == 0 && !m_busy) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    j = (m_ptr + k) % NREQ;
                    if (w < 0 && (REQ_WR[j] || REQ_RD[j])) w = j;
                end
                if (w >= 0) begin
                    m_ptr = w;
                    m_gnt = w;
                    if (REQ_WR[w]) begin
                        m_mem = WDATA[w*WIDTH +: WIDTH];
                        sched.push_back(mk(1, 1, '0, m_mem, 0, '0));
                    end else begin
                        repeat (RD_WAIT) sched.push_back(mk(0, 0, '0, '0, 0, '0));
                    end
                    sched.push_back(mk(0, 1, NREQ'(1) << w, '0, !REQ_WR[w], m_mem));
                end
            end
            if (sched.size() > 0) begin
                cur = sched.pop_front();
                m_busy = 1; m_ewr = cur.ewr; m_edy = cur.edy; m_ack = cur.ack; m_data = cur.data;
                if (cur.rd_done) m_rdata = cur.rv;
            end else begin
                m_busy = 0; m_ewr = 0; m_edy = 1; m_ack = '0; m_data = '0;
            end
        end
    end

    always @(negedge CLOCK) if (chk_en) begin
        chk("ack", ACK, m_ack);
        chk("ewr", REG_EWR, m_ewr);
        chk("edy", REG_EDY, m_edy);
        chk("busy", BUSY, m_busy);
        chk("gnt", GNT_ID, m_gnt);
        chk("rdata", RDATA, m_rdata);
        chk("reg_data", REG_DATA, m_data);
        chk("strobe_excl", REG_EWR & ~REG_EDY, 0);
    end

    // One cycle; requesters drop after ACK and optionally reassert a cycle later.
    task automatic cyc();
        @(negedge CLOCK);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin REQ_WR[i] = 1'b1; pend[i] = 1'b0; end
            if (ACK[i]) begin
                if (REQ_WR[i]) REQ_WR[i] = 1'b0; else REQ_RD[i] = 1'b0;
                if (rr) pend[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_ack(input string n, input logic [NREQ-1:0] exp);
        int t;
        t = 0;
        do begin cyc(); t++; end while (ACK == '0 && t < 60);
        chk(n, ACK, exp);
    endtask

    initial begin
        cyc(); cyc();
        chk_en = 1'b1;
        RESET = 1'b0;
        repeat (5) begin
            cyc();
            chk("idle_ewr", REG_EWR, 0); chk("idle_edy", REG_EDY, 1); chk("idle_ack", ACK, 0);
            chk("idle_busy", BUSY, 0); chk("idle_rdata", RDATA, 0);
        end
        WDATA[2*WIDTH +: WIDTH] = 8'hA5; REQ_WR[2] = 1'b1;
        cyc(); chk("wr_ewr", REG_EWR, 1); chk("wr_data", REG_DATA, 8'hA5); chk("wr_edy", REG_EDY, 1);
        cyc(); chk("wr_ack", ACK, 4'b0100);
        cyc(); chk("wr_busy", BUSY, 0); chk("wr_ack_off", ACK, 0);
        REQ_RD[1] = 1'b1;
        for (int i = 0; i < RD_WAIT; i++) begin
            cyc(); chk("rd_edy", REG_EDY, 0); chk("rd_ewr", REG_EWR, 0);
        end
        cyc(); chk("rd_ack", ACK, 4'b0010); chk("rd_data", RDATA, 8'hA5); chk("rd_edy_off", REG_EDY, 1);
        cyc();
        WDATA[3*WIDTH +: WIDTH] = 8'h5A; REQ_WR[3] = 1'b1;
        wait_ack("w3_ack", 4'b1000);
        cyc();
        WDATA = {8'h44, 8'h33, 8'h22, 8'h11};
        rr = 1'b1;
        REQ_WR = '1;
        for (int n = 0; n < 6; n++) wait_ack("rr_ack", NREQ'(1) << (n % NREQ));
        rr = 1'b0; pend = '0; REQ_WR = '0;
        cyc();
        WDATA[0 +: WIDTH] = 8'h3C; REQ_WR[0] = 1'b1; REQ_RD[0] = 1'b1;
        wait_ack("both_wr_ack", 4'b0001); chk("both_wr_rdata", RDATA, 8'hA5);
        wait_ack("both_rd_ack", 4'b0001); chk("both_rd_data", RDATA, 8'h3C);
        cyc();
        REQ_RD[2] = 1'b1;
        cyc(); chk("rst_rd1", REG_EDY, 0);
        cyc(); chk("rst_rd2", REG_EDY, 0);
        RESET = 1'b1;
        cyc();
        chk("rst_edy", REG_EDY, 1); chk("rst_busy", BUSY, 0); chk("rst_rdata", RDATA, 0);
        chk("rst_ack", ACK, 0);
        RESET = 1'b0;
        WDATA[0 +: WIDTH] = 8'hC3; REQ_WR[0] = 1'b1;
        wait_ack("rst_first", 4'b0001);
        wait_ack("rst_second", 4'b0100); chk("rst_rd_data", RDATA, 8'hC3);
        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/par_reg_arbiter.md
Name: par_reg_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one parallel storage register (D-trigger based, write strobe EWR, active-low read enable EDY) among NREQ requesters.
- Serialises write and read transactions, drives the register's data, EWR and EDY pins, and returns read data and a one-cycle acknowledge to the granted requester.
- Sits between the requester bank and the register instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width in bits.
- RD_WAIT, 1, cycles EDY is held low before read data is sampled (1..15).
- INV_READ, 1, when 1 RDATA captures ~REG_Q (the register drives inverted data); when 0 RDATA captures REG_Q unchanged.

Ports:
- CLOCK  in  1  system clock, all state updates on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- REQ_WR  in  NREQ  per-requester write request, level, held until ACK.
- REQ_RD  in  NREQ  per-requester read request, level, held until ACK.
- WDATA  in  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- ACK  out  NREQ  one-hot, one-cycle completion pulse.
- RDATA  out  WIDTH  last read result; valid in the ACK cycle and held until the next read completes.
- GNT_ID  out  clog2(NREQ)  index of the current or last granted requester.
- BUSY  out  1  high in any state other than IDLE.
- REG_DATA  out  WIDTH  data bus to the register: WDATA of the granted requester in WR, otherwise 0.
- REG_EWR  out  1  register write strobe.
- REG_EDY  out  1  register read enable, active-low.
- REG_Q  in  WIDTH  register output.

Behaviour:
- Reset values:
  - REG_EWR=0, REG_EDY=1, REG_DATA=0.
  - ACK=0, RDATA=0, GNT_ID=0, BUSY=0.
  - State=IDLE, round-robin pointer=NREQ-1, so requester 0 has first priority.
- All outputs are registered, except REG_DATA, which is a mux on the registered GNT_ID and state.
- FSM states are IDLE, WR, RD, ACK.
- IDLE:
  - A requester is active when REQ_WR[i] or REQ_RD[i] is high.
  - Search starts at pointer+1 and wraps modulo NREQ. The first active requester wins.
  - On the next edge: GNT_ID <= winner, pointer <= winner.
  - Next state is WR if REQ_WR[winner] is set, otherwise RD. Write wins when both are set; the read is served on a later grant.
  - No active requester: stay in IDLE.
- WR:
  - Exactly one cycle with REG_EWR=1 and REG_DATA=WDATA[GNT_ID]. The register captures at the closing edge.
  - Next state: ACK.
- RD:
  - REG_EDY=0 for RD_WAIT cycles, counted by a 4-bit wait counter.
  - On the last cycle's edge: RDATA <= (INV_READ ? ~REG_Q : REG_Q).
  - Next state: ACK.
- ACK:
  - ACK[GNT_ID]=1 for one cycle. REG_EWR=0, REG_EDY=1.
  - Next state: IDLE. Requests are not sampled in this cycle.
- Latency from request seen in IDLE:
  - Write: EWR in cycle +1, ACK in cycle +2.
  - Read: EDY low in cycles +1..+RD_WAIT, ACK in cycle +RD_WAIT+1.
- Requester rules:
  - A requester must drop its request in the cycle after its ACK.
  - A request still high in IDLE is treated as a new transaction.
- Fairness: with all NREQ requesters continuously active, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- A request that drops before grant is simply not served. A request that drops mid-transaction does not abort it; the ACK is still issued.
- REG_EWR and REG_EDY=0 are never asserted in the same cycle.
- RESET during WR, RD or ACK:
  - Transaction aborted, no ACK.
  - Strobes go inactive and state returns to IDLE on that edge.
  - RDATA is cleared to 0.

Decomposition:
- Shared package:
  - State encoding constants IDLE=2'd0, WR=2'd1, RD=2'd2, ACK=2'd3.
  - A clog2 function.
- One sub-module, rr_pick: purely combinational round-robin priority picker.
  - Inputs: request vector and pointer.
  - Outputs: winner index and a valid flag.
- FSM, wait counter and datapath mux stay in par_reg_arbiter.

Test Plan:
- Reset, then idle 5 cycles -> REG_EWR=0, REG_EDY=1, ACK=0, BUSY=0, RDATA=0 throughout.
- Single write: REQ_WR[2]=1 with WDATA[2]=8'hA5 -> REG_EWR=1 and REG_DATA=8'hA5 one cycle later, then ACK=4'b0100 for one cycle, then BUSY=0.
- Read after write: REQ_RD[1]=1 with a register model returning REG_Q=~8'hA5 -> REG_EDY=0 for RD_WAIT cycles, then RDATA=8'hA5 with ACK=4'b0010.
- Fairness: all four REQ_WR held, each dropped after its ACK and reasserted -> grant order 0,1,2,3,0,1 over six transactions, exactly one ACK bit per transaction.
- Same requester with REQ_WR[0]=REQ_RD[0]=1 -> write completes and is acknowledged first; read is served on a later grant.
- RESET asserted during RD, with RD_WAIT=3 and reset in the second wait cycle -> no ACK, REG_EDY=1 and BUSY=0 on the next edge, RDATA=0, next grant goes to requester 0 first.
